pw_checking: RTL and testbench
==============================

// Module: pw_checking
// PURPOSE
//  Second authentication stage, directly downstream of the user-ID checker. Once an ID match is
//  reported, it either admits a guest at once or collects a 4-digit password. The password is
//  compared against the password ROM entry indexed by the matched internal ID.
//  Drives logged_in/logged_out to the game logic and enforces a retry limit with timed lockout.
// PARAMETERS
//  ROM_LATENCY   2           cycles from addr_PW_ROM change to valid q_PW_ROM
//  PW_BASE       5'd0        ROM address of user 0's password; user n at PW_BASE+n
//  MAX_ATTEMPTS  3           wrong passwords tolerated before lockout (1..15)
//  LOCK_CYCLES   50_000_000  lockout duration in clk cycles (1 s @ 50 MHz); bench uses 20
// PORTS
//  clk          in   1   50 MHz system clock
//  rst          in   1   synchronous reset, active-high
//  pwdigit      in   4   password digit from toggle switches
//  pwenter      in   1   single-cycle pulse from button shaper; latches pwdigit
//  log_out      in   1   single-cycle pulse; ends session
//  matchID      in   1   level from ID checker: valid user ID entered
//  isGuest      in   1   level from ID checker: matched ID is guest (intID 0)
//  intID        in   3   internal user index from ID checker, valid while matchID=1
//  q_PW_ROM     in   16  password ROM data, 4 BCD digits, MSD in [15:12]
//  addr_PW_ROM  out  5   password ROM address
//  logged_in    out  1   session active
//  logged_out   out  1   ~logged_in, registered
//  pw_fail      out  1   one-cycle pulse per wrong password
//  locked_out   out  1   high during lockout
//  attempts     out  4   wrong attempts in current session
// BEHAVIOUR
//  Reset: addr_PW_ROM=0, logged_in=0, logged_out=1, pw_fail=0, locked_out=0, attempts=0, PW=0,
//   state IDLE. Reset has priority over every other input in every state.
//  States and transitions:
//   IDLE: PW<=0, attempts<=0. matchID&isGuest -> LOGGED_IN. matchID&~isGuest -> D1.
//   D1..D4: on pwenter, PW[15:12] / [11:8] / [7:4] / [3:0] <= pwdigit, then advance.
//    D4 advances to FETCH. pwenter is ignored in every other state.
//   FETCH: addr_PW_ROM <= PW_BASE + {2'b00,intID}, using 5-bit modulo arithmetic.
//   WAIT: hold for ROM_LATENCY cycles.
//   CATCH: register q_PW_ROM.
//   COMPARE:
//    - equal -> LOGGED_IN.
//    - else pw_fail=1 for this cycle only and attempts+1.
//    - if the new count = MAX_ATTEMPTS -> LOCKED, else -> D1 with PW cleared.
//   LOGGED_IN: logged_in=1, logged_out=0. log_out -> IDLE, with both flags restored the next cycle.
//   LOCKED: locked_out=1 and a counter loads LOCK_CYCLES-1.
//    - On reaching 0: locked_out=0, attempts=0 -> IDLE.
//    - log_out and pwenter are ignored.
//  Latency:
//   - Last pwenter to logged_in is 4+ROM_LATENCY cycles (FETCH, WAIT x N, CATCH, COMPARE).
//   - Guest admission is 1 cycle after matchID rises.
//  matchID falling in any state except LOGGED_IN and LOCKED -> IDLE next cycle. This covers a
//   mid-entry abort by the ID stage.
//  pwenter coincident with a state change is consumed only by the state being exited.
//  log_out and matchID-fall in the same cycle as a successful COMPARE: COMPARE wins.
//   log_out is acted on only from LOGGED_IN.
//  Unused state encodings -> IDLE.
// STRUCTURE
//  Shared package auth_pkg:
//   - state encoding localparams
//   - PW_W=16, DIGIT_W=4, ROM_AW=5, ID_W=3
//   - GUEST_ID=3'd0
//   The ID checker uses the same constants.
//  One sub-module: lockout_timer
//   - Down-counter, width $clog2(LOCK_CYCLES).
//   - Ports: clk, rst, start, busy, done_pulse.
//   - Instantiated once; FSM waits on done_pulse in LOCKED.
//  ROM is external; it shares the single-port ROM IP style used for the UID ROM.
// TESTING
//  1. Guest: matchID=1, isGuest=1, intID=0 -> logged_in=1 next cycle, addr_PW_ROM unchanged (0).
//  2. Correct password:
//     - Stimulus: intID=3, ROM[3]=16'h1234, pwenter with 1,2,3,4.
//     - Response: addr_PW_ROM=3, logged_in=1 exactly 6 cycles after 4th pwenter.
//     - Then log_out -> logged_out=1.
//  3. Wrong then right:
//     - Stimulus: ROM[3]=16'h1234, enter 1,2,3,5, then 1,2,3,4.
//     - Response: one pw_fail pulse, attempts=1, then logged_in=1.
//  4. Lockout:
//     - Stimulus: MAX_ATTEMPTS=3, LOCK_CYCLES=20; three wrong entries.
//     - Response: attempts=3, locked_out high exactly 20 cycles; pwenter ignored; then IDLE with attempts=0.
//  5. Abort/reset:
//     - Stimulus: drop matchID after 2 digits.
//     - Response: IDLE next cycle, PW=0.
//     - Also: assert rst during WAIT -> all outputs at reset values the following cycle.

Source files
------------

// File: rtl/auth_pkg.sv
// -----------------------------------------------------------------------------
// auth_pkg
// Constants and the state encoding shared by the authentication stages (the
// user-ID checker and the password checker).
// Contents:
//   PW_W, DIGIT_W, ROM_AW, ID_W, ATT_W  datapath widths
//   GUEST_ID                            internal ID reserved for the guest user
//   state_t                             password checker state encoding
//   pw_rom_addr()                       password ROM address for a user index
// -----------------------------------------------------------------------------
package auth_pkg;

    localparam int PW_W    = 16;
    localparam int DIGIT_W = 4;
    localparam int ROM_AW  = 5;
    localparam int ID_W    = 3;
    localparam int ATT_W   = 4;

    localparam logic [ID_W-1:0] GUEST_ID = 3'd0;

    localparam int STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE      = 4'd0,
        ST_D1        = 4'd1,
        ST_D2        = 4'd2,
        ST_D3        = 4'd3,
        ST_D4        = 4'd4,
        ST_FETCH     = 4'd5,
        ST_WAIT      = 4'd6,
        ST_CATCH     = 4'd7,
        ST_COMPARE   = 4'd8,
        ST_LOGGED_IN = 4'd9,
        ST_LOCKED    = 4'd10
    } state_t;

    // User n's password lives at base + n; the sum wraps within the ROM space.
    function automatic logic [ROM_AW-1:0] pw_rom_addr(input logic [ROM_AW-1:0] base,
                                                      input logic [ID_W-1:0]   id);
        return base + {{(ROM_AW - ID_W){1'b0}}, id};
    endfunction

endpackage

// File: rtl/pw_checking_if.sv
// -----------------------------------------------------------------------------
// pw_checking_if
// Signal bundle between the password checker, its environment (ID checker,
// digit entry buttons, game logic) and the external password ROM.
// Modports:
//   slave   the password checker itself
//   master  everything around it (stimulus, ID checker, ROM, consumers)
// Signals:
//   pwdigit[3:0]       password digit from toggle switches
//   pwenter            one-cycle pulse, latches pwdigit
//   log_out            one-cycle pulse, ends the session
//   matchID            level, a valid user ID has been entered
//   isGuest            level, the matched ID is the guest
//   intID[2:0]         internal user index, valid while matchID=1
//   q_PW_ROM[15:0]     password ROM data, 4 BCD digits, MSD in [15:12]
//   addr_PW_ROM[4:0]   password ROM address
//   logged_in          session active
//   logged_out         complement of logged_in
//   pw_fail            one-cycle pulse per wrong password
//   locked_out         high during lockout
//   attempts[3:0]      wrong attempts in the current session
// -----------------------------------------------------------------------------
interface pw_checking_if import auth_pkg::*; ();

    logic [DIGIT_W-1:0] pwdigit;
    logic               pwenter;
    logic               log_out;
    logic               matchID;
    logic               isGuest;
    logic [ID_W-1:0]    intID;
    logic [PW_W-1:0]    q_PW_ROM;
    logic [ROM_AW-1:0]  addr_PW_ROM;
    logic               logged_in;
    logic               logged_out;
    logic               pw_fail;
    logic               locked_out;
    logic [ATT_W-1:0]   attempts;

    modport slave (
        input  pwdigit, pwenter, log_out, matchID, isGuest, intID, q_PW_ROM,
        output addr_PW_ROM, logged_in, logged_out, pw_fail, locked_out, attempts
    );

    modport master (
        output pwdigit, pwenter, log_out, matchID, isGuest, intID, q_PW_ROM,
        input  addr_PW_ROM, logged_in, logged_out, pw_fail, locked_out, attempts
    );

endinterface

// File: rtl/lockout_timer.sv
// -----------------------------------------------------------------------------
// lockout_timer
// One-shot down-counter. A start pulse loads LOCK_CYCLES-1; the counter then
// runs down to zero. done_pulse is high in the cycle the count sits at zero,
// so busy is high for exactly LOCK_CYCLES cycles after start.
// Ports:
//   clk         system clock
//   rst         synchronous reset, active-high
//   start       load the counter and begin timing
//   busy        timer running
//   done_pulse  one-cycle pulse, last cycle of the timed interval
// -----------------------------------------------------------------------------
module lockout_timer #(
    parameter int LOCK_CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy,
    output logic done_pulse
);

    localparam int               CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LOAD  = CNT_W'(LOCK_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            busy <= 1'b0;
        end else if (start) begin
            cnt  <= LOAD;
            busy <= 1'b1;
        end else if (busy) begin
            if (cnt == '0) begin
                busy <= 1'b0;
            end else begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    assign done_pulse = busy && (cnt == '0);

endmodule

// File: rtl/pw_checking.sv
// -----------------------------------------------------------------------------
// pw_checking
// Second authentication stage behind the user-ID checker. Admits a guest
// immediately, otherwise collects four password digits, reads the matched
// user's password from the external ROM and compares. Too many wrong
// passwords lock the user out for LOCK_CYCLES cycles.
// Ports:
//   clk   system clock
//   rst   synchronous reset, active-high, overrides everything
//   bus   pw_checking_if.slave (see interface for the signal list)
//
// state       | meaning
// ------------+---------------------------------------------------------
// IDLE        | no session, waiting for an ID match
// D1..D4      | waiting for password digit 1..4
// FETCH       | drive ROM address for the matched user
// WAIT        | ROM_LATENCY cycles for the ROM data to settle
// CATCH       | register ROM data
// COMPARE     | compare entered password with stored one
// LOGGED_IN   | session active until log_out
// LOCKED      | retry limit reached, waiting for the lockout timer
// -----------------------------------------------------------------------------
module pw_checking import auth_pkg::*; #(
    parameter int                ROM_LATENCY  = 2,
    parameter logic [ROM_AW-1:0] PW_BASE      = 5'd0,
    parameter int                MAX_ATTEMPTS = 3,
    parameter int                LOCK_CYCLES  = 50_000_000
) (
    input  logic         clk,
    input  logic         rst,
    pw_checking_if.slave bus
);

    localparam int               WAIT_W    = (ROM_LATENCY > 1) ? $clog2(ROM_LATENCY) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(ROM_LATENCY - 1);
    localparam logic [ATT_W-1:0]  MAX_ATT   = ATT_W'(MAX_ATTEMPTS);

    state_t             state, next_state;
    logic [PW_W-1:0]    pw;
    logic [PW_W-1:0]    rom_word;
    logic [ROM_AW-1:0]  addr;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [ATT_W-1:0]   attempts;
    logic [ATT_W-1:0]   attempts_inc;
    logic               logged_in;
    logic               logged_out;
    logic               locked_out;
    logic               pw_match;
    logic               timer_start;
    logic               timer_busy;
    logic               timer_done;

    assign pw_match     = (pw == rom_word);
    assign attempts_inc = attempts + ATT_W'(1);

    lockout_timer #(
        .LOCK_CYCLES (LOCK_CYCLES)
    ) u_lockout_timer (
        .clk        (clk),
        .rst        (rst),
        .start      (timer_start),
        .busy       (timer_busy),
        .done_pulse (timer_done)
    );

    always_comb begin
        next_state  = state;
        timer_start = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.matchID) begin
                    next_state = bus.isGuest ? ST_LOGGED_IN : ST_D1;
                end
            end
            ST_D1: begin
                if (!bus.matchID)    next_state = ST_IDLE;
                else if (bus.pwenter) next_state = ST_D2;
            end
            ST_D2: begin
                if (!bus.matchID)    next_state = ST_IDLE;
                else if (bus.pwenter) next_state = ST_D3;
            end
            ST_D3: begin
                if (!bus.matchID)    next_state = ST_IDLE;
                else if (bus.pwenter) next_state = ST_D4;
            end
            ST_D4: begin
                if (!bus.matchID)    next_state = ST_IDLE;
                else if (bus.pwenter) next_state = ST_FETCH;
            end
            ST_FETCH: begin
                next_state = bus.matchID ? ST_WAIT : ST_IDLE;
            end
            ST_WAIT: begin
                if (!bus.matchID)         next_state = ST_IDLE;
                else if (wait_cnt == '0)  next_state = ST_CATCH;
            end
            ST_CATCH: begin
                next_state = bus.matchID ? ST_COMPARE : ST_IDLE;
            end
            ST_COMPARE: begin
                // A correct password wins over a simultaneous ID drop.
                if (pw_match) begin
                    next_state = ST_LOGGED_IN;
                end else if (!bus.matchID) begin
                    next_state = ST_IDLE;
                end else if (attempts_inc == MAX_ATT) begin
                    next_state  = ST_LOCKED;
                    timer_start = 1'b1;
                end else begin
                    next_state = ST_D1;
                end
            end
            ST_LOGGED_IN: begin
                if (bus.log_out) next_state = ST_IDLE;
            end
            ST_LOCKED: begin
                // An idle timer here can only mean a lost start; do not hang.
                if (timer_done || !timer_busy) next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            pw         <= '0;
            rom_word   <= '0;
            addr       <= '0;
            wait_cnt   <= '0;
            attempts   <= '0;
            logged_in  <= 1'b0;
            logged_out <= 1'b1;
            locked_out <= 1'b0;
        end else begin
            state      <= next_state;
            logged_in  <= (next_state == ST_LOGGED_IN);
            logged_out <= (next_state != ST_LOGGED_IN);
            locked_out <= (next_state == ST_LOCKED);

            case (state)
                ST_D1:      if (next_state == ST_D2)    pw[15:12] <= bus.pwdigit;
                ST_D2:      if (next_state == ST_D3)    pw[11:8]  <= bus.pwdigit;
                ST_D3:      if (next_state == ST_D4)    pw[7:4]   <= bus.pwdigit;
                ST_D4:      if (next_state == ST_FETCH) pw[3:0]   <= bus.pwdigit;
                ST_FETCH: begin
                    addr     <= pw_rom_addr(PW_BASE, bus.intID);
                    wait_cnt <= WAIT_LOAD;
                end
                ST_WAIT: begin
                    if (wait_cnt != '0) wait_cnt <= wait_cnt - WAIT_W'(1);
                end
                ST_CATCH: begin
                    rom_word <= bus.q_PW_ROM;
                end
                ST_COMPARE: begin
                    if (!pw_match) begin
                        attempts <= attempts_inc;
                        if (next_state == ST_D1) pw <= '0;
                    end
                end
                default: ;
            endcase

            // Every way back to IDLE forgets the entered digits and the count.
            if (next_state == ST_IDLE) begin
                pw       <= '0;
                attempts <= '0;
            end
        end
    end

    assign bus.addr_PW_ROM = addr;
    assign bus.logged_in   = logged_in;
    assign bus.logged_out  = logged_out;
    assign bus.locked_out  = locked_out;
    assign bus.attempts    = attempts;
    assign bus.pw_fail     = (state == ST_COMPARE) && !pw_match;

endmodule

// File: tb/tb_pw_checking.sv
// -----------------------------------------------------------------------------
// tb_pw_checking
// Self-checking bench for pw_checking with a two-stage ROM model.
// -----------------------------------------------------------------------------
module tb_pw_checking;
    import auth_pkg::*;

    localparam int ROM_LAT  = 2;
    localparam int MAX_ATT  = 3;
    localparam int LOCK_CYC = 20;

    localparam int KIND_NONE  = 0;
    localparam int KIND_LOGIN = 1;
    localparam int KIND_FAIL  = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pw_checking_if bus();

    pw_checking #(
        .ROM_LATENCY  (ROM_LAT),
        .PW_BASE      (5'd0),
        .MAX_ATTEMPTS (MAX_ATT),
        .LOCK_CYCLES  (LOCK_CYC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [15:0] rom [32];
    logic [15:0] rom_s1;

    always @(posedge clk) begin
        rom_s1       <= rom[bus.addr_PW_ROM];
        bus.q_PW_ROM <= rom_s1;
    end

    typedef struct {
        int kind;
        int lat;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns one cycle after the final pwenter has been sampled.
    task automatic enter_pw(input logic [15:0] code);
        for (int i = 0; i < 4; i++) begin
            bus.pwdigit = code[15 - 4*i -: 4];
            bus.pwenter = 1'b1;
            tick();
            bus.pwenter = 1'b0;
            if (i < 3) tick();
        end
    endtask

    // Latency counts the final pwenter cycle as cycle 1.
    task automatic wait_result(output int kind, output int lat);
        bit done;
        kind = KIND_NONE;
        lat  = 1;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            tick();
            lat++;
            if (bus.logged_in) begin
                kind = KIND_LOGIN;
                done = 1'b1;
            end else if (bus.pw_fail) begin
                kind = KIND_FAIL;
                done = 1'b1;
            end
        end
    endtask

    task automatic logout();
        bus.log_out = 1'b1;
        bus.matchID = 1'b0;
        bus.isGuest = 1'b0;
        tick();
        bus.log_out = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_tests++; if (bus.addr_PW_ROM !== 5'd0) begin n_fail++; $display("FAIL reset_addr: got %0d expected 0", bus.addr_PW_ROM); end
        n_tests++; if (bus.logged_in !== 1'b0) begin n_fail++; $display("FAIL reset_logged_in: got %b expected 0", bus.logged_in); end
        n_tests++; if (bus.logged_out !== 1'b1) begin n_fail++; $display("FAIL reset_logged_out: got %b expected 1", bus.logged_out); end
        n_tests++; if (bus.pw_fail !== 1'b0) begin n_fail++; $display("FAIL reset_pw_fail: got %b expected 0", bus.pw_fail); end
        n_tests++; if (bus.locked_out !== 1'b0) begin n_fail++; $display("FAIL reset_locked_out: got %b expected 0", bus.locked_out); end
        n_tests++; if (bus.attempts !== 4'd0) begin n_fail++; $display("FAIL reset_attempts: got %0d expected 0", bus.attempts); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_guest();
        bus.matchID = 1'b1;
        bus.isGuest = 1'b1;
        bus.intID   = GUEST_ID;
        tick();
        n_tests++; if (bus.logged_in !== 1'b1) begin n_fail++; $display("FAIL guest_logged_in: got %b expected 1", bus.logged_in); end
        n_tests++; if (bus.logged_out !== 1'b0) begin n_fail++; $display("FAIL guest_logged_out: got %b expected 0", bus.logged_out); end
        n_tests++; if (bus.addr_PW_ROM !== 5'd0) begin n_fail++; $display("FAIL guest_addr: got %0d expected 0", bus.addr_PW_ROM); end
        logout();
        n_tests++; if (bus.logged_out !== 1'b1 || bus.logged_in !== 1'b0) begin n_fail++; $display("FAIL guest_logout: got in=%b out=%b expected in=0 out=1", bus.logged_in, bus.logged_out); end
        tick();
    endtask

    task automatic test_correct();
        int   k, l;
        exp_t e;
        bus.matchID = 1'b1;
        bus.isGuest = 1'b0;
        bus.intID   = 3'd3;
        tick();
        exp_q.push_back('{KIND_LOGIN, 4 + ROM_LAT});
        enter_pw(16'h1234);
        wait_result(k, l);
        e = exp_q.pop_front();
        n_tests++; if (k !== e.kind || l !== e.lat) begin n_fail++; $display("FAIL correct_login: got kind=%0d lat=%0d expected kind=%0d lat=%0d", k, l, e.kind, e.lat); end
        n_tests++; if (bus.addr_PW_ROM !== 5'd3) begin n_fail++; $display("FAIL correct_addr: got %0d expected 3", bus.addr_PW_ROM); end
        logout();
        n_tests++; if (bus.logged_out !== 1'b1 || bus.logged_in !== 1'b0) begin n_fail++; $display("FAIL correct_logout: got in=%b out=%b expected in=0 out=1", bus.logged_in, bus.logged_out); end
        tick();
    endtask

    task automatic test_wrong_then_right();
        int   k, l;
        exp_t e;
        bus.matchID = 1'b1;
        bus.isGuest = 1'b0;
        bus.intID   = 3'd3;
        tick();
        exp_q.push_back('{KIND_FAIL, 3 + ROM_LAT});
        enter_pw(16'h1235);
        wait_result(k, l);
        e = exp_q.pop_front();
        n_tests++; if (k !== e.kind || l !== e.lat) begin n_fail++; $display("FAIL wrong_fail: got kind=%0d lat=%0d expected kind=%0d lat=%0d", k, l, e.kind, e.lat); end
        tick();
        n_tests++; if (bus.pw_fail !== 1'b0) begin n_fail++; $display("FAIL wrong_pulse_width: got %b expected 0", bus.pw_fail); end
        n_tests++; if (bus.attempts !== 4'd1) begin n_fail++; $display("FAIL wrong_attempts: got %0d expected 1", bus.attempts); end
        exp_q.push_back('{KIND_LOGIN, 4 + ROM_LAT});
        enter_pw(16'h1234);
        wait_result(k, l);
        e = exp_q.pop_front();
        n_tests++; if (k !== e.kind || l !== e.lat) begin n_fail++; $display("FAIL retry_login: got kind=%0d lat=%0d expected kind=%0d lat=%0d", k, l, e.kind, e.lat); end
        n_tests++; if (bus.attempts !== 4'd1) begin n_fail++; $display("FAIL retry_attempts: got %0d expected 1", bus.attempts); end
        logout();
        tick();
    endtask

    task automatic test_lockout();
        int   k, l;
        int   lock_cnt;
        bit   stray;
        exp_t e;
        logic [15:0] code;
        bus.matchID = 1'b1;
        bus.isGuest = 1'b0;
        bus.intID   = 3'd3;
        tick();
        for (int a = 0; a < MAX_ATT; a++) begin
            code = 16'h4321 + 16'(a);
            exp_q.push_back('{KIND_FAIL, 3 + ROM_LAT});
            enter_pw(code);
            wait_result(k, l);
            e = exp_q.pop_front();
            n_tests++; if (k !== e.kind || l !== e.lat) begin n_fail++; $display("FAIL lock_attempt%0d: got kind=%0d lat=%0d expected kind=%0d lat=%0d", a, k, l, e.kind, e.lat); end
            if (a < MAX_ATT - 1) tick();
        end
        lock_cnt = 0;
        stray    = 1'b0;
        for (int i = 0; i < 60; i++) begin
            bus.pwdigit = 4'h7;
            bus.pwenter = (i % 3 == 0);
            bus.log_out = (i % 5 == 0);
            tick();
            if (bus.logged_in || bus.pw_fail) stray = 1'b1;
            if (bus.locked_out) begin
                lock_cnt++;
                if (lock_cnt == 1) begin
                    n_tests++; if (bus.attempts !== 4'(MAX_ATT)) begin n_fail++; $display("FAIL lock_attempts: got %0d expected %0d", bus.attempts, MAX_ATT); end
                end
            end else if (lock_cnt > 0) begin
                break;
            end
        end
        bus.pwenter = 1'b0;
        bus.log_out = 1'b0;
        n_tests++; if (lock_cnt !== LOCK_CYC) begin n_fail++; $display("FAIL lock_duration: got %0d expected %0d", lock_cnt, LOCK_CYC); end
        n_tests++; if (stray !== 1'b0) begin n_fail++; $display("FAIL lock_ignored_inputs: got stray=%b expected 0", stray); end
        n_tests++; if (bus.attempts !== 4'd0) begin n_fail++; $display("FAIL lock_exit_attempts: got %0d expected 0", bus.attempts); end
        n_tests++; if (dut.state !== ST_IDLE) begin n_fail++; $display("FAIL lock_exit_state: got %0d expected %0d", dut.state, ST_IDLE); end
        bus.matchID = 1'b0;
        tick();
    endtask

    task automatic test_abort();
        bus.matchID = 1'b1;
        bus.isGuest = 1'b0;
        bus.intID   = 3'd3;
        tick();
        bus.pwdigit = 4'h1; bus.pwenter = 1'b1; tick(); bus.pwenter = 1'b0; tick();
        bus.pwdigit = 4'h2; bus.pwenter = 1'b1; tick(); bus.pwenter = 1'b0; tick();
        n_tests++; if (dut.pw !== 16'h1200) begin n_fail++; $display("FAIL abort_partial_pw: got %h expected 1200", dut.pw); end
        bus.matchID = 1'b0;
        tick();
        n_tests++; if (dut.state !== ST_IDLE) begin n_fail++; $display("FAIL abort_state: got %0d expected %0d", dut.state, ST_IDLE); end
        n_tests++; if (dut.pw !== 16'h0000) begin n_fail++; $display("FAIL abort_pw: got %h expected 0000", dut.pw); end
        tick();
    endtask

    task automatic test_reset_in_wait();
        bus.matchID = 1'b1;
        bus.isGuest = 1'b0;
        bus.intID   = 3'd3;
        tick();
        enter_pw(16'h1234);
        tick();
        n_tests++; if (dut.state !== ST_WAIT) begin n_fail++; $display("FAIL rstwait_precondition: got %0d expected %0d", dut.state, ST_WAIT); end
        rst = 1'b1;
        tick();
        n_tests++; if (bus.addr_PW_ROM !== 5'd0 || bus.logged_in !== 1'b0 || bus.logged_out !== 1'b1 ||
                       bus.pw_fail !== 1'b0 || bus.locked_out !== 1'b0 || bus.attempts !== 4'd0) begin
            n_fail++;
            $display("FAIL rstwait_outputs: got addr=%0d in=%b out=%b fail=%b lock=%b att=%0d expected 0 0 1 0 0 0",
                     bus.addr_PW_ROM, bus.logged_in, bus.logged_out, bus.pw_fail, bus.locked_out, bus.attempts);
        end
        n_tests++; if (dut.state !== ST_IDLE) begin n_fail++; $display("FAIL rstwait_state: got %0d expected %0d", dut.state, ST_IDLE); end
        rst = 1'b0;
        bus.matchID = 1'b0;
        tick();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rom[i] = 16'h9000 + 16'(i);
        rom[3] = 16'h1234;
        rst         = 1'b1;
        bus.pwdigit = '0;
        bus.pwenter = 1'b0;
        bus.log_out = 1'b0;
        bus.matchID = 1'b0;
        bus.isGuest = 1'b0;
        bus.intID   = '0;

        test_reset();
        test_guest();
        test_correct();
        test_wrong_then_right();
        test_lockout();
        test_abort();
        test_reset_in_wait();

        n_tests++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size()); end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
